// File: rtl/piso_shift_tx_if.sv
// Load handshake and serial output bundle for piso_shift_tx.
// The master drives the word; the slave is the transmitter.
interface piso_shift_tx_if #(
    parameter int unsigned WIDTH = 4
);
    logic             load_valid;
    logic [WIDTH-1:0] d_par;
    logic             load_ready;
    logic             q;
    logic             q_valid;
    logic             busy;
    logic             done;

    modport master (
        output load_valid,
        output d_par,
        input  load_ready,
        input  q,
        input  q_valid,
        input  busy,
        input  done
    );

    modport slave (
        input  load_valid,
        input  d_par,
        output load_ready,
        output q,
        output q_valid,
        output busy,
        output done
    );
endinterface

// File: rtl/piso_shift_tx.sv
// Parallel-in, serial-out transmitter: WIDTH-bit word in, one bit per clk out, MSB first.
// Define PISO_PARITY_EN to append one even-parity bit after the last data bit of each word.
module piso_shift_tx #(
    parameter int unsigned WIDTH = 4
) (
    input  logic           clk,
    input  logic           rst,
    piso_shift_tx_if.slave bus
);
    localparam int unsigned     CntW    = $clog2(WIDTH);
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StParity} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] shreg_q, shreg_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             q_q, q_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             load_ready;
    logic             accept;
`ifdef PISO_PARITY_EN
    logic             par_q, par_d;
`endif

    // Ready on the last-bit cycle lets words stream without a gap bit.
`ifdef PISO_PARITY_EN
    assign load_ready = (state_q == StIdle) || (state_q == StParity);
`else
    assign load_ready = (state_q == StIdle) || ((state_q == StShift) && (cnt_q == '0));
`endif
    assign accept     = bus.load_valid && load_ready;

    always_comb begin
        state_d = state_q;
        shreg_d = shreg_q;
        cnt_d   = cnt_q;
`ifdef PISO_PARITY_EN
        par_d   = par_q;
`endif

        unique case (state_q)
            StIdle: begin
            end
            StShift: begin
                if (cnt_q != '0) begin
                    shreg_d = {shreg_q[WIDTH-2:0], 1'b0};
                    cnt_d   = cnt_q - CntW'(1);
                end else begin
`ifdef PISO_PARITY_EN
                    state_d = StParity;
`else
                    state_d = StIdle;
`endif
                    shreg_d = '0;
                    cnt_d   = '0;
                end
            end
`ifdef PISO_PARITY_EN
            StParity: begin
                state_d = StIdle;
            end
`endif
            default: begin
                state_d = StIdle;
                shreg_d = '0;
                cnt_d   = '0;
            end
        endcase

        // A load only happens where the word would otherwise end, so it overrides.
        if (accept) begin
            state_d = StShift;
            shreg_d = bus.d_par;
            cnt_d   = CntLast;
`ifdef PISO_PARITY_EN
            par_d   = ^bus.d_par;
`endif
        end

        busy_d = (state_d != StIdle);
        q_d    = (state_d == StShift) ? shreg_d[WIDTH-1] : 1'b0;
`ifdef PISO_PARITY_EN
        if (state_d == StParity) begin
            q_d = par_d;
        end
        done_d = (state_d == StParity);
`else
        done_d = (state_d == StShift) && (cnt_d == '0);
`endif
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            shreg_q <= '0;
            cnt_q   <= '0;
            q_q     <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef PISO_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            q_q     <= q_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef PISO_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign bus.load_ready = load_ready;
    assign bus.q          = q_q;
    assign bus.q_valid    = busy_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
endmodule
